// File: rtl/mem_wr_32to8_ctrl_pkg.sv
// mem_wr_32to8_ctrl_pkg: state encoding, word geometry and byte-lane helper for the 32-to-8 write controller
package mem_wr_32to8_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;
  localparam int BYTES_PER_WORD = 4;
  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/mem_wr_32to8_ctrl.sv
// mem_wr_32to8_ctrl: serialises 32-bit word writes into byte writes and zero-fills the RAM on demand
module mem_wr_32to8_ctrl
  import mem_wr_32to8_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-3:0] s_addr,
  input  logic [31:0]       s_data,
  input  logic [3:0]        s_be,
  input  logic              clr_req,
  output logic              busy,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddress,
  output logic [7:0]        data
);
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
  state_t            r_state, w_next;
  // extra MSB flags that the last fill address has already been emitted
  logic [ADDR_W:0]   r_cnt, w_cnt;
  logic [1:0]        r_k, w_k, w_k1;
  logic [ADDR_W-3:0] r_addr;
  logic [31:0]       r_word;
  logic [3:0]        r_be;
  logic              r_wren, w_wren;
  logic [ADDR_W-1:0] r_wraddress, w_wraddress;
  logic [7:0]        r_data, w_data;
  logic              w_last, w_done, w_accept;
  assign w_last    = r_k == 2'(BYTES_PER_WORD - 1);
  assign w_done    = r_cnt[ADDR_W];
  assign w_k1      = r_k + 2'd1;
  assign s_ready   = (r_state == ST_IDLE && !clr_req) || (r_state == ST_WRITE && w_last);
  assign w_accept  = s_valid && s_ready;
  assign busy      = r_state != ST_IDLE;
  assign wren      = r_wren;
  assign wraddress = r_wraddress;
  assign data      = r_data;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_k         <= '0;
      r_wren      <= 1'b0;
      r_wraddress <= '0;
      r_data      <= '0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_k         <= w_k;
      r_wren      <= w_wren;
      r_wraddress <= w_wraddress;
      r_data      <= w_data;
    end
  end
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_addr <= s_addr;
      r_word <= s_data;
      r_be   <= s_be;
    end
  end
  always_comb begin
    case (r_state)
      ST_CLEAR: w_next = w_done ? ST_IDLE : ST_CLEAR;
      ST_IDLE:  w_next = clr_req ? ST_CLEAR : (s_valid ? ST_WRITE : ST_IDLE);
      ST_WRITE: w_next = !w_last ? ST_WRITE : (s_valid ? ST_WRITE : ST_IDLE);
      default:  w_next = RST_STATE;
    endcase
  end
  always_comb begin
    w_wren      = 1'b0;
    w_wraddress = r_wraddress;
    w_data      = r_data;
    w_cnt       = r_cnt;
    w_k         = r_k;
    if (r_state == ST_CLEAR && !w_done) begin
      w_wren      = 1'b1;
      w_wraddress = r_cnt[ADDR_W-1:0];
      w_data      = 8'h00;
      w_cnt       = r_cnt + (ADDR_W + 1)'(1);
    end else if (w_accept) begin
      w_wren      = s_be[0];
      w_wraddress = {s_addr, 2'b00};
      w_data      = byte_lane(s_data, 2'd0);
      w_k         = 2'd0;
    end else if (r_state == ST_WRITE && !w_last) begin
      w_wren      = r_be[w_k1];
      w_wraddress = {r_addr, w_k1};
      w_data      = byte_lane(r_word, w_k1);
      w_k         = w_k1;
    end else if (r_state == ST_IDLE && clr_req) begin
      w_cnt = '0;
    end
  end
endmodule

// File: tb/tb_mem_wr_32to8_ctrl.sv
// tb_mem_wr_32to8_ctrl: directed and randomized checks of the 32-to-8 write controller against a byte-slot model
module tb_mem_wr_32to8_ctrl;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } slot_t;
  logic clock = 1'b0, reset = 1'b1, s_valid = 1'b0, clr_req = 1'b0, fill = 1'b1;
  logic [ADDR_W-3:0] s_addr = '0;
  logic [31:0]       s_data = '0;
  logic [3:0]        s_be = '0;
  logic              s_ready, busy, wren;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        data;
  logic [7:0]        ram [DEPTH];
  logic [7:0]        ref_mem [DEPTH];
  slot_t             slots[$];
  int                clr_phase = -1;
  int                checks = 0, errors = 0, wr_cnt = 0, busy_cnt = 0;
  bit                acc;

  mem_wr_32to8_ctrl #(.ADDR_W(ADDR_W), .CLEAR_ON_RESET(1'b1)) dut (
    .clock(clock), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .s_be(s_be), .clr_req(clr_req),
    .busy(busy), .wren(wren), .wraddress(wraddress), .data(data)
  );

  always #5 clock = ~clock;

  // stand-in for the RAM write port, preloaded with 0xFF
  always @(posedge clock) begin
    if (fill) for (int i = 0; i < DEPTH; i++) ram[i] <= 8'hFF;
    else if (wren) ram[wraddress] <= data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input int w);
    return {ram[4*w+3], ram[4*w+2], ram[4*w+1], ram[4*w]};
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  // one cycle: check outputs against the model, then advance the model across the coming edge
  task automatic tick();
    slot_t s;
    logic e_busy, e_ready;
    #1;
    s = '0;
    if (clr_phase >= 1) s = '{1'b1, ADDR_W'(clr_phase - 1), 8'h00};
    else if (clr_phase < 0 && slots.size() > 0) s = slots[0];
    e_busy  = clr_phase >= 0 || slots.size() > 0;
    e_ready = clr_phase < 0 && (slots.size() == 1 || (slots.size() == 0 && !clr_req));
    chk("wren", wren, s.en);
    if (s.en) begin
      chk("wraddress", wraddress, s.a);
      chk("data", data, s.d);
    end
    chk("busy", busy, e_busy);
    chk("s_ready", s_ready, e_ready);
    wr_cnt   += wren ? 1 : 0;
    busy_cnt += busy ? 1 : 0;
    acc = e_ready && s_valid;
    if (s.en) ref_mem[s.a] = s.d;
    if (reset) begin
      clr_phase = 0;
      slots.delete();
    end else if (clr_phase >= 0) begin
      clr_phase = clr_phase == DEPTH ? -1 : clr_phase + 1;
    end else begin
      if (slots.size() > 0) void'(slots.pop_front());
      else if (clr_req) clr_phase = 0;
      if (acc)
        for (int k = 0; k < 4; k++)
          slots.push_back('{s_be[k], {s_addr, 2'(k)}, s_data[8*k +: 8]});
    end
    @(negedge clock);
  endtask

  initial begin
    int n, last;
    foreach (ref_mem[i]) ref_mem[i] = 8'hFF;
    @(negedge clock);
    fill = 1'b0;
    @(negedge clock);
    clr_phase = 0;
    chk("rst wren", wren, 0);
    chk("rst wraddress", wraddress, 0);
    chk("rst data", data, 0);
    chk("rst busy", busy, 1);
    chk("rst s_ready", s_ready, 0);
    // power-on clear
    reset = 1'b0;
    wr_cnt = 0;
    repeat (DEPTH + 2) tick();
    chk("clear wren cycles", wr_cnt, DEPTH);
    for (int w = 0; w < DEPTH / 4; w++) chk("cleared word", ram_word(w), 32'h0);
    // single full word
    s_addr = 8'h05; s_data = 32'hDDCCBBAA; s_be = 4'hF; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    wr_cnt = 0;
    repeat (5) tick();
    chk("full word bytes", wr_cnt, 4);
    chk("full word read", ram_word(5), 32'hDDCCBBAA);
    // partial byte enables
    s_addr = 8'h06; s_data = 32'h44332211; s_be = 4'b0101; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    wr_cnt = 0;
    repeat (5) tick();
    chk("partial bytes", wr_cnt, 2);
    chk("partial read", ram_word(6), 32'h00330011);
    // back-to-back words
    s_addr = 8'h10; s_data = $urandom; s_be = 4'hF; s_valid = 1'b1;
    wr_cnt = 0; busy_cnt = 0; n = 0; last = -4;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (acc) begin
        chk("b2b spacing", i - last, 4);
        last = i; n++;
        s_addr = s_addr + 1'b1; s_data = $urandom;
        if (n == 3) s_valid = 1'b0;
      end
    end
    chk("b2b accepts", n, 3);
    chk("b2b wren cycles", wr_cnt, 12);
    chk("b2b busy cycles", busy_cnt, 12);
    for (int w = 16; w < 19; w++) chk("b2b read", ram_word(w), ref_word(w));
    // clear request wins over a pending word
    s_addr = 8'h07; s_data = 32'h0BADF00D; s_be = 4'hF; s_valid = 1'b1; clr_req = 1'b1;
    tick();
    chk("clr blocks accept", acc, 0);
    clr_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!acc && n < 1100);
    chk("accept after clear", n, DEPTH + 2);
    s_valid = 1'b0;
    repeat (5) tick();
    chk("word after clear", ram_word(7), 32'h0BADF00D);
    chk("clear wiped b2b", ram_word(16), 32'h0);
    // reset while byte 1 is on the bus
    s_addr = 8'h09; s_data = 32'h87654321; s_be = 4'hF; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("byte1 landed", ram[37], 8'h43);
    chk("byte2 dropped", ram[38], 8'h00);
    chk("byte3 dropped", ram[39], 8'h00);
    repeat (DEPTH + 2) tick();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_addr  = ADDR_W'($urandom) >> 2;
      s_data  = $urandom;
      s_be    = 4'($urandom);
      clr_req = $urandom_range(0, 299) == 0;
      tick();
    end
    s_valid = 1'b0; clr_req = 1'b0; n = 0;
    while ((clr_phase >= 0 || slots.size() > 0) && n < 2200) begin tick(); n++; end
    chk("drain in time", n < 2200, 1);
    tick();
    for (int w = 0; w < DEPTH / 4; w++) chk("final word", ram_word(w), ref_word(w));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
